// File: rtl/data_memory_pkg.sv
// data_memory_pkg
// Shared ISA definitions for the MEM stage: datapath widths and the
// memory access mode encodings driven from the EX/MEM pipeline register.
// No ports; imported by data_memory and mem_load_extend.

package data_memory_pkg;

    localparam int WORD = 32;
    localparam int MMD  = 3;

    typedef enum logic [MMD-1:0] {
        MEM_WORD  = 3'd0,
        MEM_HALF  = 3'd1,
        MEM_HALFU = 3'd2,
        MEM_BYTE  = 3'd3,
        MEM_BYTEU = 3'd4
    } mem_mode_e;

    // Number of bytes a store of this mode touches; 0 for undefined modes.
    function automatic int unsigned store_bytes(input logic [MMD-1:0] mode);
        case (mode)
            MEM_WORD:             store_bytes = 4;
            MEM_HALF, MEM_HALFU:  store_bytes = 2;
            MEM_BYTE, MEM_BYTEU:  store_bytes = 1;
            default:              store_bytes = 0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_extend.sv
// mem_load_extend
// Turns the four raw little-endian bytes fetched at the access address into
// the final load value: selects word/half/byte and applies sign or zero
// extension. Forces zero when the load is not enabled or the mode is undefined.
// Ports:
//   raw       in  [WORD-1:0] bytes A..A+3, byte A in bits [7:0]
//   mode      in  [MMD-1:0]  access size / extension
//   read_en   in             load enable
//   read_data out [WORD-1:0] extended load result

module mem_load_extend
    import data_memory_pkg::*;
(
    input  logic [WORD-1:0] raw,
    input  logic [MMD-1:0]  mode,
    input  logic            read_en,
    output logic [WORD-1:0] read_data
);

    always_comb begin
        read_data = '0;
        if (read_en) begin
            case (mode)
                MEM_WORD:  read_data = raw;
                MEM_HALF:  read_data = {{16{raw[15]}}, raw[15:0]};
                MEM_HALFU: read_data = {16'h0000, raw[15:0]};
                MEM_BYTE:  read_data = {{24{raw[7]}}, raw[7:0]};
                MEM_BYTEU: read_data = {24'h000000, raw[7:0]};
                default:   read_data = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// data_memory
// Byte-addressed, little-endian data memory for the MEM stage. Stores of
// word/half/byte size happen on the rising edge; loads are combinational.
// Any byte address is legal; each of the four byte lanes wraps modulo DEPTH
// on its own, so unaligned and end-of-memory accesses need no special casing.
// Optional macro DATAMEM_TRACE_EN: prints every accepted store in simulation.
// Parameters:
//   DEPTH      memory size in bytes, power of two
// Ports:
//   clk        in             rising-edge clock
//   rst_n      in             synchronous active-low reset, clears all bytes
//   address    in  [WORD-1:0] byte address (low log2(DEPTH) bits used)
//   writeData  in  [WORD-1:0] store data, low bytes used for half/byte
//   mode       in  [MMD-1:0]  access size and extension
//   memRead    in             load enable
//   memWrite   in             store enable
//   readData   out [WORD-1:0] load result

module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH = 1024
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] writeData,
    input  logic [MMD-1:0]  mode,
    input  logic            memRead,
    input  logic            memWrite,
    output logic [WORD-1:0] readData
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] lane [4];
    logic [WORD-1:0] raw;

    // Bits above the memory size are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[WORD-1:AW];

    // Lane k is A+k truncated to AW bits, which gives the modulo-DEPTH wrap.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane[k] = address[AW-1:0] + AW'(k);
        end
    end

    // Reset clears every byte and wins over a store on the same edge.
    // Otherwise the lanes covered by the access size take the low bytes of
    // writeData; undefined modes cover no lanes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (memWrite) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(store_bytes(mode))) begin
                    mem[lane[k]] <= writeData[8*k +: 8];
                end
            end
        end
    end

    assign raw = {mem[lane[3]], mem[lane[2]], mem[lane[1]], mem[lane[0]]};

    mem_load_extend u_load_extend (
        .raw       (raw),
        .mode      (mode),
        .read_en   (memRead),
        .read_data (readData)
    );

`ifdef DATAMEM_TRACE_EN
    always @(posedge clk) begin
        if (rst_n && memWrite && store_bytes(mode) != 0) begin
            $display("[DATAMEM] t=%0t addr=0x%08h mode=%0d data=0x%08h",
                     $time, address, mode, writeData);
        end
    end
`endif

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory
// Randomised and directed checks of data_memory against a byte-array model.
// The model lives as a plain array of bytes with modulo-DEPTH indexing; a
// single compare process checks readData against it on every falling edge,
// and literal expectations from hand calculation pin both DUT and model.

module tb_data_memory;
    import data_memory_pkg::*;

    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [WORD-1:0] address;
    logic [WORD-1:0] write_data;
    logic [MMD-1:0]  mode;
    logic            mem_read;
    logic            mem_write;
    logic [WORD-1:0] read_data;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    byte unsigned model_mem [DEPTH];

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .writeData (write_data),
        .mode      (mode),
        .memRead   (mem_read),
        .memWrite  (mem_write),
        .readData  (read_data)
    );

    always #5 clk = ~clk;

    // Load value from the byte model following the access rules directly.
    function automatic logic [31:0] model_load(input logic [31:0] a,
                                               input logic [2:0] m,
                                               input logic rd);
        int base;
        logic [31:0] w;
        base = int'(a % DEPTH);
        w = {model_mem[(base+3) % DEPTH], model_mem[(base+2) % DEPTH],
             model_mem[(base+1) % DEPTH], model_mem[base]};
        if (!rd) return 32'h0;
        case (m)
            3'd0: return w;
            3'd1: return {{16{w[15]}}, w[15:0]};
            3'd2: return {16'h0, w[15:0]};
            3'd3: return {{24{w[7]}}, w[7:0]};
            3'd4: return {24'h0, w[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then mirror it in the model.
    task automatic applyStimulus(input logic r, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [2:0] m,
                                 input logic rd, input logic wr);
        int n;
        rst_n = r; address = a; write_data = wd; mode = m;
        mem_read = rd; mem_write = wr;
        @(posedge clk);
        if (!r) begin
            foreach (model_mem[i]) model_mem[i] = 8'h00;
        end else if (wr) begin
            case (m)
                3'd0: n = 4;
                3'd1, 3'd2: n = 2;
                3'd3, 3'd4: n = 1;
                default: n = 0;
            endcase
            for (int k = 0; k < n; k++)
                model_mem[(int'(a % DEPTH) + k) % DEPTH] = wd[8*k +: 8];
        end
        #1;
    endtask

    // Combinational load check against a hand-computed literal; the model
    // is held to the same literal.
    task automatic checkOutput(input string name, input logic [31:0] a,
                               input logic [2:0] m, input logic rd,
                               input logic [31:0] expected);
        address = a; mode = m; mem_read = rd; mem_write = 1'b0;
        #1;
        check(name, read_data, expected);
        check({name, "_model"}, model_load(a, m, rd), expected);
    endtask

    always @(negedge clk) begin
        if (check_en)
            check("cycle", read_data, model_load(address, mode, mem_read));
    end

    initial begin
        rst_n = 1'b1; address = '0; write_data = '0; mode = '0;
        mem_read = 1'b0; mem_write = 1'b0;
        foreach (model_mem[i]) model_mem[i] = 8'h00;
        #2;

        applyStimulus(1'b0, 32'd0, 32'h0, 3'd0, 1'b1, 1'b0);
        check_en = 1'b1;
        checkOutput("reset_word0", 32'd0, 3'd0, 1'b1, 32'h0000_0000);
        checkOutput("read_disabled", 32'd0, 3'd0, 1'b0, 32'h0000_0000);

        applyStimulus(1'b1, 32'd10, 32'hdead_0000, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd18, 32'h0000_beef, 3'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd18, 32'h1234_5678, 3'd0, 1'b1, 1'b0);
        checkOutput("unaligned_10", 32'd10, 3'd0, 1'b1, 32'hdead_0000);
        checkOutput("unaligned_18", 32'd18, 3'd0, 1'b1, 32'h0000_beef);

        applyStimulus(1'b1, 32'd0, 32'h1122_3344, 3'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd1, 32'h0000_00aa, 3'd3, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'd2, 32'h0000_beef, 3'd1, 1'b0, 1'b1);
        checkOutput("substore_word0", 32'd0, 3'd0, 1'b1, 32'hbeef_aa44);

        applyStimulus(1'b1, 32'd0, 32'h80ff_7f01, 3'd0, 1'b0, 1'b1);
        checkOutput("byte_s_2", 32'd2, 3'd3, 1'b1, 32'hffff_ffff);
        checkOutput("byte_u_2", 32'd2, 3'd4, 1'b1, 32'h0000_00ff);
        checkOutput("half_s_2", 32'd2, 3'd1, 1'b1, 32'hffff_80ff);
        checkOutput("half_u_0", 32'd0, 3'd2, 1'b1, 32'h0000_7f01);
        checkOutput("byte_s_1", 32'd1, 3'd3, 1'b1, 32'h0000_007f);

        applyStimulus(1'b1, 32'd1022, 32'ha1b2_c3d4, 3'd0, 1'b0, 1'b1);
        checkOutput("wrap_byte0", 32'd0, 3'd4, 1'b1, 32'h0000_00b2);
        checkOutput("wrap_byte1023", 32'd1023, 3'd4, 1'b1, 32'h0000_00c3);
        checkOutput("wrap_word1022", 32'd1022, 3'd0, 1'b1, 32'ha1b2_c3d4);
        checkOutput("wrap_high_addr", 32'h0000_07fe, 3'd0, 1'b1, 32'ha1b2_c3d4);

        applyStimulus(1'b1, 32'd40, 32'h5555_5555, 3'd5, 1'b1, 1'b1);
        checkOutput("undef_mode_load", 32'd40, 3'd5, 1'b1, 32'h0000_0000);
        checkOutput("undef_mode_nostore", 32'd40, 3'd0, 1'b1, 32'h0000_0000);

        applyStimulus(1'b0, 32'd4, 32'hffff_ffff, 3'd0, 1'b1, 1'b1);
        checkOutput("reset_priority", 32'd4, 3'd0, 1'b1, 32'h0000_0000);

        // Random traffic concentrated on a small window plus the wrap edge
        // so stores and loads overlap often.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 2))
                0: a = $urandom_range(0, 31);
                1: a = DEPTH - 4 + $urandom_range(0, 7);
                default: a = $urandom;
            endcase
            applyStimulus(($urandom_range(0, 99) != 0), a, $urandom,
                          3'($urandom_range(0, 7)), 1'($urandom),
                          ($urandom_range(0, 2) != 0));
        end

        for (int i = 0; i < 64; i++) begin
            applyStimulus(1'b1, 32'($urandom_range(0, 40)), 32'h0,
                          3'($urandom_range(0, 4)), 1'b1, 1'b0);
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
